// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//   In-order queue of in-flight control-flow predictions. Fetch pushes
//   {pc, taken, target}. Execute resolves the oldest entry. A wrong
//   prediction raises a one-cycle redirect (mispred/r_addr) and flushes the
//   whole queue. Every accepted resolve also emits one predictor training
//   record (upd_*).
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   pred_valid/pc/taken/target, pred_ready   prediction enqueue interface
//   res_valid/taken/target                   resolution of the oldest entry
//   mispred, r_addr                          registered redirect pulse / address
//   upd_valid/pc/taken/target                registered training record
//   count                                    current queue occupancy
//   stat_branches, stat_mispred              statistics counters
//
// Configuration
//   BRANCH_STATS_EN   when defined, the statistics counters are built;
//                     otherwise both statistics outputs are tied to zero.
// -----------------------------------------------------------------------------
module branch_resolve #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [31:0]              pred_pc,
  input  logic                     pred_taken,
  input  logic [31:0]              pred_target,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [31:0]              res_target,
  output logic                     mispred,
  output logic [31:0]              r_addr,
  output logic                     upd_valid,
  output logic [31:0]              upd_pc,
  output logic                     upd_taken,
  output logic [31:0]              upd_target,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_mispred
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   pc_mem     [DEPTH];
  logic          taken_mem  [DEPTH];
  logic [31:0]   target_mem [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;

  logic          enq, pop, mis_now;
  logic [31:0]   head_pc, head_target, rec_addr;
  logic          head_taken;

  assign head_pc     = pc_mem[rd_ptr];
  assign head_taken  = taken_mem[rd_ptr];
  assign head_target = target_mem[rd_ptr];

  assign pred_ready = (count < DEPTH_C) && !mispred;
  assign enq        = pred_valid && pred_ready;
  assign pop        = res_valid && (count != '0);

  // A not-taken branch has no meaningful target, so compare targets only
  // when the actual outcome is taken.
  assign mis_now  = pop && ((res_taken != head_taken) ||
                            (res_taken && (res_target != head_target)));
  assign rec_addr = res_taken ? res_target : (head_pc + 32'd4);

  // Entry storage carries no reset; occupancy and pointers decide validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr]     <= pred_pc;
      taken_mem[wr_ptr]  <= pred_taken;
      target_mem[wr_ptr] <= pred_target;
    end
  end

  // On a mispredict the flush overrides any same-cycle enqueue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mis_now) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(enq) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispred    <= 1'b0;
      r_addr     <= '0;
      upd_valid  <= 1'b0;
      upd_pc     <= '0;
      upd_taken  <= 1'b0;
      upd_target <= '0;
    end else begin
      mispred   <= mis_now;
      upd_valid <= pop;
      if (mis_now) r_addr <= rec_addr;
      if (pop) begin
        upd_pc     <= head_pc;
        upd_taken  <= res_taken;
        upd_target <= res_target;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop)     stat_branches <= stat_branches + 32'd1;
      if (mis_now) stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
//   Directed testbench for branch_resolve (DEPTH=4). Each scenario task drives
//   stimulus and compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken, pred_ready;
  logic [31:0] pred_pc, pred_target;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        mispred, upd_valid, upd_taken;
  logic [31:0] r_addr, upd_pc, upd_target;
  logic [2:0]  count;
  logic [31:0] stat_branches, stat_mispred;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  branch_resolve #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .mispred(mispred), .r_addr(r_addr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .count(count),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tg;
    step();
    pred_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
    checks++; if (mispred !== 1'b0) $display("FAIL reset_mispred got %0b exp 0", mispred); else passed++;
    checks++; if (r_addr !== 32'h0) $display("FAIL reset_raddr got %h exp 0", r_addr); else passed++;
    checks++; if (upd_valid !== 1'b0) $display("FAIL reset_upd_valid got %0b exp 0", upd_valid); else passed++;
    checks++; if (pred_ready !== 1'b1) $display("FAIL reset_ready got %0b exp 1", pred_ready); else passed++;
  endtask

  task automatic test_correct();
    enq(32'h100, 1'b1, 32'h200);
    checks++; if (count !== 3'd1) $display("FAIL corr_count1 got %0d exp 1", count); else passed++;
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h200;
    step();
    res_valid = 1'b0;
    checks++; if (mispred !== 1'b0) $display("FAIL corr_mispred got %0b exp 0", mispred); else passed++;
    checks++; if (upd_valid !== 1'b1) $display("FAIL corr_upd_valid got %0b exp 1", upd_valid); else passed++;
    checks++; if (upd_pc !== 32'h100) $display("FAIL corr_upd_pc got %h exp 100", upd_pc); else passed++;
    checks++; if (upd_target !== 32'h200) $display("FAIL corr_upd_tgt got %h exp 200", upd_target); else passed++;
    checks++; if (count !== 3'd0) $display("FAIL corr_count0 got %0d exp 0", count); else passed++;
    step();
    checks++; if (upd_valid !== 1'b0) $display("FAIL corr_upd_pulse got %0b exp 0", upd_valid); else passed++;
  endtask

  task automatic test_mispred_taken();
    enq(32'h104, 1'b0, 32'h0);
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h300;
    step();
    res_valid = 1'b0;
    checks++; if (mispred !== 1'b1) $display("FAIL mt_mispred got %0b exp 1", mispred); else passed++;
    checks++; if (r_addr !== 32'h300) $display("FAIL mt_raddr got %h exp 300", r_addr); else passed++;
    checks++; if (upd_taken !== 1'b1) $display("FAIL mt_upd_taken got %0b exp 1", upd_taken); else passed++;
    checks++; if (pred_ready !== 1'b0) $display("FAIL mt_ready got %0b exp 0", pred_ready); else passed++;
    step();
    checks++; if (mispred !== 1'b0) $display("FAIL mt_pulse got %0b exp 0", mispred); else passed++;
    checks++; if (r_addr !== 32'h300) $display("FAIL mt_raddr_hold got %h exp 300", r_addr); else passed++;
    checks++; if (pred_ready !== 1'b1) $display("FAIL mt_ready2 got %0b exp 1", pred_ready); else passed++;
  endtask

  task automatic test_flush();
    enq(32'h108, 1'b1, 32'h400);
    enq(32'h10C, 1'b0, 32'h0);
    enq(32'h110, 1'b0, 32'h0);
    enq(32'h114, 1'b0, 32'h0);
    checks++; if (count !== 3'd4) $display("FAIL fl_count4 got %0d exp 4", count); else passed++;
    res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0;
    step();
    res_valid = 1'b0;
    checks++; if (mispred !== 1'b1) $display("FAIL fl_mispred got %0b exp 1", mispred); else passed++;
    checks++; if (r_addr !== 32'h10C) $display("FAIL fl_raddr got %h exp 10c", r_addr); else passed++;
    checks++; if (count !== 3'd0) $display("FAIL fl_count0 got %0d exp 0", count); else passed++;
    step();
  endtask

  task automatic test_full_and_wrap();
    for (int i = 0; i < 4; i++) enq(32'h500 + 32'(4*i), 1'b0, 32'h0);
    checks++; if (pred_ready !== 1'b0) $display("FAIL full_ready got %0b exp 0", pred_ready); else passed++;
    enq(32'h600, 1'b0, 32'h0);
    checks++; if (count !== 3'd4) $display("FAIL full_drop got %0d exp 4", count); else passed++;
    for (int i = 0; i < 4; i++) begin
      res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0;
      step();
      checks++; if (upd_pc !== 32'h500 + 32'(4*i))
        $display("FAIL full_order%0d got %h exp %h", i, upd_pc, 32'h500 + 32'(4*i)); else passed++;
    end
    res_valid = 1'b0;
    checks++; if (count !== 3'd0) $display("FAIL full_drained got %0d exp 0", count); else passed++;
    enq(32'hA00, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      pred_valid = 1'b1; pred_pc = 32'hA00 + 32'(4*(i+1)); pred_taken = 1'b0; pred_target = 32'h0;
      res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0;
      step();
      checks++; if (upd_pc !== 32'hA00 + 32'(4*i) || count !== 3'd1 || mispred !== 1'b0)
        $display("FAIL wrap%0d got pc %h cnt %0d exp pc %h cnt 1", i, upd_pc, count, 32'hA00 + 32'(4*i)); else passed++;
    end
    pred_valid = 1'b0;
    step();
    checks++; if (upd_pc !== 32'hA18 || count !== 3'd0)
      $display("FAIL wrap_last got pc %h cnt %0d exp pc a18 cnt 0", upd_pc, count); else passed++;
    res_valid = 1'b0;
    step();
  endtask

  task automatic test_mispred_block();
    enq(32'h700, 1'b0, 32'h0);
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h780;
    step();
    res_valid = 1'b0;
    pred_valid = 1'b1; pred_pc = 32'h800; pred_taken = 1'b0; pred_target = 32'h0;
    step();
    pred_valid = 1'b0;
    checks++; if (count !== 3'd0) $display("FAIL blk_count got %0d exp 0", count); else passed++;
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h900;
    step();
    res_valid = 1'b0;
    checks++; if (upd_valid !== 1'b0) $display("FAIL empty_upd got %0b exp 0", upd_valid); else passed++;
    checks++; if (mispred !== 1'b0 || r_addr !== 32'h780)
      $display("FAIL empty_mis got %0b %h exp 0 780", mispred, r_addr); else passed++;
  endtask

  task automatic test_async_reset();
    enq(32'hB00, 1'b0, 32'h0);
    enq(32'hB04, 1'b0, 32'h0);
    enq(32'hB08, 1'b0, 32'h0);
    checks++; if (count !== 3'd3) $display("FAIL ar_count3 got %0d exp 3", count); else passed++;
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'hC00;
    #2 rst = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || mispred !== 1'b0 || upd_valid !== 1'b0)
      $display("FAIL ar_imm got cnt %0d mis %0b upd %0b exp 0 0 0", count, mispred, upd_valid); else passed++;
    checks++; if (r_addr !== 32'h0 || upd_pc !== 32'h0 || upd_target !== 32'h0)
      $display("FAIL ar_regs got %h %h %h exp 0", r_addr, upd_pc, upd_target); else passed++;
    step();
    res_valid = 1'b0;
    checks++; if (mispred !== 1'b0 || upd_valid !== 1'b0)
      $display("FAIL ar_cancel got mis %0b upd %0b exp 0 0", mispred, upd_valid); else passed++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_stats();
    logic [31:0] exp_b, exp_m;
    for (int i = 0; i < 10; i++) begin
      enq(32'hD00 + 32'(4*i), 1'b0, 32'h0);
      res_valid = 1'b1; res_taken = (i < 3); res_target = 32'hE00;
      step();
      res_valid = 1'b0;
      step();
    end
`ifdef BRANCH_STATS_EN
    exp_b = 32'd10; exp_m = 32'd3;
`else
    exp_b = 32'd0; exp_m = 32'd0;
`endif
    checks++; if (stat_branches !== exp_b) $display("FAIL stat_br got %0d exp %0d", stat_branches, exp_b); else passed++;
    checks++; if (stat_mispred !== exp_m) $display("FAIL stat_mis got %0d exp %0d", stat_mispred, exp_m); else passed++;
  endtask

  initial begin
    rst = 1'b0;
    pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    #12;
    test_reset();
    @(posedge clk); #1 rst = 1'b1;
    step();
    test_correct();
    test_mispred_taken();
    test_flush();
    test_full_and_wrap();
    test_mispred_block();
    test_async_reset();
    test_stats();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight prediction queue depth (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pred_valid  input  1  fetch presents a control-flow prediction.
REQ-005 SHALL have port pred_pc  input  32  address of predicted instruction.
REQ-006 SHALL have port pred_taken  input  1  predicted direction.
REQ-007 SHALL have port pred_target  input  32  predicted target (meaningful when pred_taken=1).
REQ-008 SHALL have port pred_ready  output  1  queue can accept an entry.
REQ-009 SHALL have port res_valid  input  1  execute resolves the oldest outstanding branch/jump.
REQ-010 SHALL have port res_taken  input  1  actual direction.
REQ-011 SHALL have port res_target  input  32  actual target.
REQ-012 SHALL have port mispred  output  1  one-cycle redirect pulse to fetch.
REQ-013 SHALL have port r_addr  output  32  recovery fetch address, valid with mispred.
REQ-014 SHALL have port upd_valid, upd_pc[31:0], upd_taken, upd_target[31:0]  output  predictor training record.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-016 SHALL have ports stat_branches, stat_mispred  output  32  statistics counters.

Function
REQ-017 SHALL hold entries {pc, taken, target} in an in-order circular FIFO; read/write pointers wrap modulo DEPTH.
REQ-018 SHALL drive pred_ready = (count < DEPTH) && !mispred, combinationally from registered state.
REQ-019 SHALL enqueue on rising edge when pred_valid && pred_ready; pred_valid while pred_ready=0 is dropped, not stalled.
REQ-020 SHALL pop head on rising edge when res_valid && count>0; res_valid with count=0 SHALL be ignored (no pop, no outputs).
REQ-021 SHALL flag misprediction when res_taken != head.taken, or res_taken=1 and res_target != head.target.
REQ-022 SHALL set recovery address = res_target if res_taken else head.pc+4 (modulo 2^32).
REQ-023 SHALL register mispred and r_addr: asserted exactly the cycle after the resolving edge, for one cycle; r_addr holds last value otherwise.
REQ-024 SHALL on misprediction flush the whole queue (count=0, pointers equal) at the resolving edge; same-cycle enqueue is discarded.
REQ-025 SHALL while mispred=1 accept no enqueue (wrong-path fetch); ordinary enqueue resumes the following cycle.
REQ-026 SHALL simultaneous enqueue and correct-prediction pop: both occur, count unchanged; allowed when full only if pred_ready=1 (i.e. not when full).
REQ-027 SHALL pulse upd_valid for one cycle after every accepted resolve, correct or not, with upd_pc=head.pc, upd_taken=res_taken, upd_target=res_target.
REQ-028 SHALL consecutive res_valid cycles each resolve the new head; back-to-back mispredictions impossible since queue is empty after the first.

Reset
REQ-029 SHALL on rst=0 clear queue (count=0, pointers=0), mispred=0, r_addr=0, upd_valid=0, upd_pc=0, upd_taken=0, upd_target=0, stat counters=0, immediately and asynchronously.
REQ-030 SHALL when reset asserted mid-operation discard all entries; pending mispred/upd pulses are cancelled.

Configuration
REQ-031 SHALL with BRANCH_STATS_EN defined increment stat_branches on every accepted resolve and stat_mispred on every misprediction, both wrapping at 2^32.
REQ-032 SHALL without BRANCH_STATS_EN tie stat_branches and stat_mispred to 0 and instantiate no counter flops.

Verification
REQ-033 SHALL cover: enqueue pc=0x100 taken=1 target=0x200; resolve taken=1 target=0x200 -> mispred stays 0, upd_valid=1 next cycle with upd_pc=0x100, count 1->0.
REQ-034 SHALL cover: enqueue pc=0x104 taken=0; resolve taken=1 target=0x300 -> mispred=1 for one cycle, r_addr=0x300.
REQ-035 SHALL cover: enqueue pc=0x108 taken=1 target=0x400; resolve taken=0 -> r_addr=0x10C; 3 younger entries flushed, count=0.
REQ-036 SHALL cover: fill DEPTH=4 entries -> pred_ready=0, 5th pred_valid dropped; pointer wrap after 6 enq/pop pairs preserves order.
REQ-037 SHALL cover: pred_valid during mispred cycle -> not enqueued, count remains 0; res_valid with count=0 -> no upd_valid.
REQ-038 SHALL cover: rst low with count=3 and mispred pending -> all outputs 0 immediately; with BRANCH_STATS_EN, 10 resolves incl. 3 mispredicts -> stat_branches=10, stat_mispred=3.
